// File: rtl/dmem_responder.sv
// Data-memory responder: combinational-read RAM plus MMIO (LED, timer/compare, switches, fault).
// Define DMEM_TIMER_EN to build the timer, compare register and TimerIrq.
module dmem_responder #(
   parameter int ADDR_WIDTH = 6,
   parameter int PRESCALE   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   input  logic [7:0]  Switches,
   output logic [7:0]  Leds,
   output logic        TimerIrq,
   output logic        Fault
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] word_idx;
   logic [1:0]            mmio_sel;
   logic                  is_mmio;
   logic                  aligned;
   logic                  store_ok;
   logic                  ram_we;
   logic                  wr_led;
   logic                  wr_timer;
   logic                  wr_cmp;
   logic [7:0]            leds_reg;
   logic                  fault_reg;
   logic [7:0]            sw_meta_reg;
   logic [7:0]            sw_sync_reg;
   logic [31:0]           timer_rd;
   logic [31:0]           status_rd;
   logic                  unused_addr_bits;

   assign word_idx  = ALUResult[ADDR_WIDTH+1:2];
   assign mmio_sel  = ALUResult[3:2];
   assign is_mmio   = ALUResult[31];
   assign aligned   = (ALUResult[1:0] == 2'b00);
   assign store_ok  = MemWrite && aligned;
   // Gating with reset keeps a store coinciding with reset assertion out of the RAM.
   assign ram_we    = store_ok && !is_mmio && reset;
   assign wr_led    = store_ok && is_mmio && (mmio_sel == 2'd0);
   assign wr_timer  = store_ok && is_mmio && (mmio_sel == 2'd1);
   assign wr_cmp    = store_ok && is_mmio && (mmio_sel == 2'd2);
   assign unused_addr_bits = ^ALUResult[30:ADDR_WIDTH+2];

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[word_idx] <= WriteData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         leds_reg    <= '0;
         fault_reg   <= 1'b0;
         sw_meta_reg <= '0;
         sw_sync_reg <= '0;
      end else begin
         sw_meta_reg <= Switches;
         sw_sync_reg <= sw_meta_reg;
         if (wr_led) begin
            leds_reg <= WriteData[7:0];
         end
         if (MemWrite && !aligned) begin
            fault_reg <= 1'b1;
         end
      end
   end

`ifdef DMEM_TIMER_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_reg;
   logic          tick;
   logic [31:0]   timer_reg;
   logic [31:0]   timer_next;
   logic [30:0]   cmp_reg;
   logic [30:0]   cmp_next;
   logic          match_reg;
   logic          match_next;

   assign tick = (presc_reg == PRESC_LAST);

   // Match is an event on TIMER loading a value; a set on the same edge beats a clear.
   always_comb begin
      timer_next = timer_reg;
      if (wr_timer) begin
         timer_next = WriteData;
      end else if (tick) begin
         timer_next = timer_reg + 32'd1;
      end
      cmp_next   = wr_cmp ? WriteData[30:0] : cmp_reg;
      match_next = match_reg;
      if (wr_cmp && WriteData[31]) begin
         match_next = 1'b0;
      end
      if ((wr_timer || tick) && (timer_next[30:0] == cmp_next)) begin
         match_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_reg <= '0;
         timer_reg <= '0;
         cmp_reg   <= '1;
         match_reg <= 1'b0;
      end else begin
         presc_reg <= tick ? '0 : presc_reg + 1'b1;
         timer_reg <= timer_next;
         cmp_reg   <= cmp_next;
         match_reg <= match_next;
      end
   end

   assign timer_rd  = timer_reg;
   assign status_rd = {match_reg, cmp_reg};
   assign TimerIrq  = match_reg;
`else
   logic [31:0] unused_prescale;
   logic        unused_timer_bits;

   assign unused_prescale   = 32'(PRESCALE);
   assign unused_timer_bits = ^{WriteData[31:8], wr_timer, wr_cmp};
   assign timer_rd  = '0;
   assign status_rd = '0;
   assign TimerIrq  = 1'b0;
`endif

   always_comb begin
      ReadData = '0;
      if (!is_mmio) begin
         ReadData = mem[word_idx];
      end else begin
         case (mmio_sel)
            2'd0:    ReadData = {24'd0, leds_reg};
            2'd1:    ReadData = timer_rd;
            2'd2:    ReadData = status_rd;
            default: ReadData = {24'd0, sw_sync_reg};
         endcase
      end
   end

   assign Leds  = leds_reg;
   assign Fault = fault_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder; load expectations go through a scoreboard queue.
// Timer checks are built when DMEM_TIMER_EN is defined, disabled-timer checks otherwise.
module tb_dmem_responder;
   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [7:0]  Switches;
   logic [7:0]  Leds;
   logic        TimerIrq;
   logic        Fault;

   int errors = 0;
   int checks = 0;
   int cyc;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];

   dmem_responder #(.ADDR_WIDTH(6), .PRESCALE(4)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
      .WriteData(WriteData), .ReadData(ReadData), .Switches(Switches),
      .Leds(Leds), .TimerIrq(TimerIrq), .Fault(Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since reset release: after edge k, cyc == k.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, act);
      end
   endtask

   // Drive a store from a negedge; returns just after the committing edge.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      ALUResult = addr;
      WriteData = data;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1 MemWrite = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      exp_t e;
      exp_q.push_back('{tag, exp});
      ALUResult = addr;
      #1;
      e = exp_q.pop_front();
      check(e.tag, ReadData, e.val);
   endtask

   task automatic wait_cyc(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (cyc != k && n < 200);
      if (cyc != k) check("wait_cyc", 32'(cyc), 32'(k));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; Switches = '0;
      repeat (2) @(negedge clk);
      check("rst_leds", {24'd0, Leds}, 32'd0);
      check("rst_fault", {31'd0, Fault}, 32'd0);
      check("rst_irq", {31'd0, TimerIrq}, 32'd0);
      rd("rst_led_rd", 32'h8000_0000, 32'd0);
      rd("rst_timer_rd", 32'h8000_0004, 32'd0);
`ifdef DMEM_TIMER_EN
      rd("rst_status_rd", 32'h8000_0008, 32'h7FFF_FFFF);
      @(negedge clk);
      reset = 1'b1;
      wr(32'h8000_0008, 32'd3);
      wait_cyc(11);
      rd("tmr_e11", 32'h8000_0004, 32'd2);
      check("irq_e11", {31'd0, TimerIrq}, 32'd0);
      wait_cyc(12);
      rd("tmr_e12", 32'h8000_0004, 32'd3);
      check("irq_e12", {31'd0, TimerIrq}, 32'd1);
      wr(32'h8000_0008, 32'h8000_0003);
      check("irq_clr", {31'd0, TimerIrq}, 32'd0);
      @(negedge clk);
      rd("status_clr", 32'h8000_0008, 32'h0000_0003);
      wait_cyc(19);
      wr(32'h8000_0004, 32'd100);
      @(negedge clk);
      rd("wr_beats_tick", 32'h8000_0004, 32'd100);
      wait_cyc(24);
      rd("tmr_after_wr", 32'h8000_0004, 32'd101);
      wr(32'h8000_0004, 32'd3);
      @(negedge clk);
      check("irq_by_write", {31'd0, TimerIrq}, 32'd1);
`else
      @(negedge clk);
      reset = 1'b1;
      wr(32'h8000_0004, 32'd123);
      wr(32'h8000_0008, 32'h8000_0005);
      @(negedge clk);
      rd("notmr_timer", 32'h8000_0004, 32'd0);
      rd("notmr_status", 32'h8000_0008, 32'd0);
      check("notmr_irq", {31'd0, TimerIrq}, 32'd0);
`endif
      // RAM round trip, alias, read-during-write
      @(negedge clk);
      wr(32'h0000_0010, 32'hDEAD_BEEF);
      @(negedge clk);
      rd("ram_rt", 32'h0000_0010, 32'hDEAD_BEEF);
      rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
      @(negedge clk);
      WriteData = 32'h1111_1111;
      MemWrite  = 1'b1;
      rd("ram_rdw_old", 32'h0000_0010, 32'hDEAD_BEEF);
      @(posedge clk);
      #1 MemWrite = 1'b0;
      @(negedge clk);
      rd("ram_rdw_new", 32'h0000_0010, 32'h1111_1111);
      // Misaligned store
      wr(32'h0000_0020, 32'hCAFE_F00D);
      @(negedge clk);
      check("fault_pre", {31'd0, Fault}, 32'd0);
      wr(32'h0000_0022, 32'h1234_5678);
      check("fault_set", {31'd0, Fault}, 32'd1);
      @(negedge clk);
      rd("mis_word", 32'h0000_0020, 32'hCAFE_F00D);
      rd("mis_read", 32'h0000_0022, 32'hCAFE_F00D);
      check("fault_sticky", {31'd0, Fault}, 32'd1);
      // LED and switches
      @(negedge clk);
      wr(32'h8000_0000, 32'h0000_01A5);
      check("leds", {24'd0, Leds}, 32'h0000_00A5);
      @(negedge clk);
      rd("led_rd", 32'h8000_0000, 32'h0000_00A5);
      wr(32'h8000_0001, 32'h0000_0000);
      check("led_mis_supp", {24'd0, Leds}, 32'h0000_00A5);
      @(negedge clk);
      Switches = 8'h3C;
      @(negedge clk);
      rd("sw_edge1", 32'h8000_000C, 32'd0);
      @(negedge clk);
      rd("sw_edge2", 32'h8000_000C, 32'h0000_003C);
      wr(32'h8000_000C, 32'h0000_0000);
      @(negedge clk);
      rd("sw_ro", 32'h8000_000C, 32'h0000_003C);
      // Asynchronous reset between edges
      wr(32'h8000_0000, 32'h0000_00FF);
      @(negedge clk);
      check("leds_ff", {24'd0, Leds}, 32'h0000_00FF);
`ifdef DMEM_TIMER_EN
      check("irq_pre_rst", {31'd0, TimerIrq}, 32'd1);
`endif
      #2 reset = 1'b0;
      #1;
      check("arst_leds", {24'd0, Leds}, 32'd0);
      check("arst_fault", {31'd0, Fault}, 32'd0);
      check("arst_irq", {31'd0, TimerIrq}, 32'd0);
      rd("arst_timer", 32'h8000_0004, 32'd0);
      rd("arst_sw", 32'h8000_000C, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
